timer_arbiter: RTL

- Shares one 5-bit saturating cycle counter (`counter32` style: async clear, increments each clock, sticks at 31) among NREQ multi-cycle requesters, for example multiplier, divider and servo-step units.
- Grants the counter to one requester at a time and holds the counter cleared while it is idle.
- Sequences a timed run of the requested length, then pulses a per-requester done.
- Sits between the requesting units and the counter instance. It owns the counter's clear input and reads the counter's output.

---
 rtl/timer_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/timer_arbiter.sv
// ---------------------------------------------------------------------------
// timer_arbiter
//
// Shares one 5-bit saturating cycle counter among NREQ multi-cycle
// requesters. While idle the counter is held cleared. A granted requester
// gets a timed run of len_eff cycles (len==0 is treated as 1), followed by a
// one-cycle done pulse. The arbiter then returns to IDLE for one cycle before
// the next grant.
//
// Arbitration is round-robin by default: the search starts at the index after
// the last owner to complete or abort. When the macro TIMER_ARB_FIXED_PRIO_EN
// is defined, the lowest requesting index always wins and no pointer register
// is built.
//
// Ports:
//   clock    in   1        system clock, rising edge
//   reset    in   1        asynchronous, active-high reset
//   req      in   NREQ     level requests, held until done
//   len      in   NREQ*LW  run length of requester i in len[i*LW +: LW]
//   cnt_val  in   LW       output of the shared counter
//   cnt_clr  out  1        clear for the shared counter (clrn = ~cnt_clr)
//   grant    out  NREQ     one-hot owner, or all zero
//   done     out  NREQ     one-cycle completion pulse for the owner
//   busy     out  1        high in RUN or DONE
// ---------------------------------------------------------------------------
module timer_arbiter #(
    parameter int NREQ = 4,
    parameter int LW   = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*LW-1:0] len,
    input  logic [LW-1:0]      cnt_val,
    output logic               cnt_clr,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [LW-1:0]    len_m1;     // len_eff - 1, the counter value of the last RUN cycle

    logic             found;
    logic [IDX_W-1:0] winner;
    logic [LW-1:0]    win_len;
    int               idx;
    logic [IDX_W-1:0] owner_next;
    logic [NREQ-1:0]  owner_oh;

`ifndef TIMER_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0] ptr;
`endif

    // Winner search: first set request starting at the pointer (or at index
    // 0 for fixed priority), wrapping modulo NREQ.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        win_len = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef TIMER_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (int'(ptr) + k) % NREQ;
`endif
            if (!found && req[idx]) begin
                found   = 1'b1;
                winner  = IDX_W'(idx);
                win_len = len[idx*LW +: LW];
            end
        end
    end

    assign owner_next = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + IDX_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            owner <= '0;
`ifndef TIMER_ARB_FIXED_PRIO_EN
            ptr   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        owner <= winner;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Dropping the request aborts the run without a done pulse.
                    if (!req[owner]) begin
                        state <= S_IDLE;
`ifndef TIMER_ARB_FIXED_PRIO_EN
                        ptr   <= owner_next;
`endif
                    end else if (cnt_val == len_m1) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
`ifndef TIMER_ARB_FIXED_PRIO_EN
                    ptr   <= owner_next;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The length is data: it is captured only on the IDLE->RUN transition and
    // needs no reset because RUN cannot be entered without this capture.
    always_ff @(posedge clock) begin
        if (state == S_IDLE && found) begin
            len_m1 <= (win_len == '0) ? '0 : win_len - LW'(1);
        end
    end

    // Outputs decode purely from registered state and owner. The counter is
    // released only in RUN, so it reads 0 in the first RUN cycle.
    assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner;
    assign cnt_clr  = (state != S_RUN);
    assign busy     = (state != S_IDLE);
    assign grant    = (state != S_IDLE) ? owner_oh : '0;
    assign done     = (state == S_DONE) ? owner_oh : '0;

endmodule
